instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, instruction register and RUN/STALL/HALT control.
// Optional FETCH_EARLY_JUMP_EN: a captured non-halting JUMP redirects the PC at fetch.
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic [5:0]  imem_addr,
  output logic        imem_ir_enable,
  input  logic [16:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [5:0]  redirect_addr,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [16:0] id_instruction,
  output logic [5:0]  id_pc,
  output logic        halted
);

  localparam logic [3:0] OpJump = 4'b1011;

  typedef enum logic [1:0] {StRun, StStall, StHalt} state_e;

  state_e      state_q, state_d;
  logic [5:0]  pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [16:0] instr_q, instr_d;
  logic [5:0]  id_pc_q, id_pc_d;
  logic        capture;
  logic        is_jump;
  logic        is_halt;

  assign is_jump = (imem_instruction[15:12] == OpJump);
  // A JUMP to its own address is the halt idiom.
  assign is_halt = is_jump && (imem_instruction[5:0] == pc_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    capture = 1'b0;

    if (redirect_valid) begin
      pc_d    = redirect_addr;
      valid_d = 1'b0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun, StStall: begin
          if (!valid_q || id_ready) begin
            capture = 1'b1;
          end else begin
            state_d = StStall;
          end
        end
        StHalt: begin
          if (id_ready) valid_d = 1'b0;
        end
        default: state_d = StRun;
      endcase
    end

    if (capture) begin
      instr_d = imem_instruction;
      id_pc_d = pc_q;
      valid_d = 1'b1;
      if (is_halt) begin
        state_d = StHalt;
      end else begin
        state_d = StRun;
        pc_d    = pc_q + 6'd1;
`ifdef FETCH_EARLY_JUMP_EN
        if (is_jump) pc_d = imem_instruction[5:0];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= 6'd0;
      valid_q <= 1'b0;
      instr_q <= 17'd0;
      id_pc_q <= 6'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
    end
  end

  assign imem_addr      = pc_q;
  assign imem_ir_enable = capture && !reset;
  assign id_valid       = valid_q;
  assign id_instruction = instr_q;
  assign id_pc          = id_pc_q;
  assign halted         = (state_q == StHalt);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed table, corner sequences,
// and random traffic against a behavioural model (honours FETCH_EARLY_JUMP_EN).
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic        imem_ir_enable;
  logic [16:0] imem_instruction;
  logic        redirect_valid;
  logic [5:0]  redirect_addr;
  logic        id_ready;
  logic        id_valid;
  logic [16:0] id_instruction;
  logic [5:0]  id_pc;
  logic        halted;

  logic [16:0] mem [64];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [5:0]  m_pc = 6'd0;
  logic        m_v = 1'b0;
  logic [16:0] m_ir = 17'd0;
  logic [5:0]  m_ipc = 6'd0;
  logic        m_h = 1'b0;

  typedef struct {
    logic       rst;
    logic       rv;
    logic [5:0] ra;
    logic       rdy;
    logic       en;
    logic       v;
    logic [5:0] pc;
    logic       h;
  } vec_t;

  vec_t tbl [22];

  always #5 clk = ~clk;

  assign imem_instruction = mem[imem_addr];

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_addr        (imem_addr),
    .imem_ir_enable   (imem_ir_enable),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .id_ready         (id_ready),
    .id_valid         (id_valid),
    .id_instruction   (id_instruction),
    .id_pc            (id_pc),
    .halted           (halted)
  );

  function automatic vec_t mk(logic rst, logic rv, logic [5:0] ra, logic rdy,
                              logic en, logic v, logic [5:0] pc, logic h);
    vec_t t;
    t.rst = rst; t.rv = rv; t.ra = ra; t.rdy = rdy;
    t.en = en; t.v = v; t.pc = pc; t.h = h;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic rv, input logic [5:0] ra, input logic rdy);
    reset = rst;
    redirect_valid = rv;
    redirect_addr = ra;
    id_ready = rdy;
  endtask

  function automatic logic model_en();
    return !reset && !redirect_valid && !m_h && (!m_v || id_ready);
  endfunction

  // One clock edge of the fetch rules, computed from the current inputs and memory.
  task automatic model_edge();
    logic [16:0] w;
    if (reset) begin
      m_pc = 6'd0; m_v = 1'b0; m_ir = 17'd0; m_ipc = 6'd0; m_h = 1'b0;
    end else if (redirect_valid) begin
      m_pc = redirect_addr; m_v = 1'b0; m_h = 1'b0;
    end else if (m_h) begin
      if (id_ready) m_v = 1'b0;
    end else if (!m_v || id_ready) begin
      w = mem[m_pc];
      m_ir = w;
      m_ipc = m_pc;
      m_v = 1'b1;
      if (w[15:12] == 4'b1011 && w[5:0] == m_pc) begin
        m_h = 1'b1;
      end else begin
        m_pc = 6'((int'(m_pc) + 1) % 64);
`ifdef FETCH_EARLY_JUMP_EN
        if (w[15:12] == 4'b1011) m_pc = w[5:0];
`endif
      end
    end
  endtask

  // Call about 2 time units after a rising edge, with inputs already driven.
  task automatic step();
    chk("ir_enable", 32'(imem_ir_enable), 32'(model_en()));
    if (!reset) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    @(posedge clk);
    model_edge();
    #1;
    chk("id_valid", 32'(id_valid), 32'(m_v));
    chk("halted", 32'(halted), 32'(m_h));
    if (m_v) begin
      chk("id_pc", 32'(id_pc), 32'(m_ipc));
      chk("id_instruction", 32'(id_instruction), 32'(m_ir));
    end
  endtask

  task automatic cyc(input logic rst, input logic rv, input logic [5:0] ra, input logic rdy);
    drive(rst, rv, ra, rdy);
    #1;
    step();
  endtask

  initial begin
    drive(1'b1, 1'b0, 6'd0, 1'b1);
    for (int i = 0; i < 64; i++) mem[i] = {i[0], 4'b0001, 6'd0, i[5:0]};
    mem[7] = 17'h0B007;

    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 1, 2, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 1, 3, 0);
    tbl[5]  = mk(0, 0, 0, 1, 1, 1, 4, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 4, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 4, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 4, 0);
    tbl[9]  = mk(0, 0, 0, 1, 1, 1, 5, 0);
    tbl[10] = mk(0, 0, 0, 1, 1, 1, 6, 0);
    tbl[11] = mk(0, 1, 1, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 1, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 1, 1, 1, 2, 0);
    tbl[14] = mk(0, 1, 6, 1, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 1, 1, 6, 0);
    tbl[16] = mk(0, 0, 0, 1, 1, 1, 7, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 7, 1);
    tbl[18] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    tbl[19] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    tbl[20] = mk(0, 1, 0, 1, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 1, 1, 1, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].ra, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d_en", i), 32'(imem_ir_enable), 32'(tbl[i].en));
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(id_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].h));
      if (tbl[i].v) chk($sformatf("tbl%0d_pc", i), 32'(id_pc), 32'(tbl[i].pc));
      if (i == 17 || i == 19) chk($sformatf("tbl%0d_frozen", i), 32'(imem_addr), 32'd7);
    end

    // JUMP to 1 sitting at address 6
    mem[6] = 17'h0B001;
    cyc(1, 0, 0, 1);
    cyc(0, 1, 6, 1);
    cyc(0, 0, 0, 1);
    chk("jump_src_pc", 32'(id_pc), 32'd6);
    cyc(0, 0, 0, 1);
`ifdef FETCH_EARLY_JUMP_EN
    chk("jump_next_pc", 32'(id_pc), 32'd1);
`else
    chk("jump_next_pc", 32'(id_pc), 32'd7);
`endif
    chk("jump_next_valid", 32'(id_valid), 32'd1);

    // PC wrap 63 -> 0
    cyc(0, 1, 6'd63, 1);
    cyc(0, 0, 0, 1);
    chk("wrap_pc63", 32'(id_pc), 32'd63);
    cyc(0, 0, 0, 1);
    chk("wrap_pc0", 32'(id_pc), 32'd0);

    // Reset mid-halt discards everything
    cyc(0, 1, 7, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pre_reset_halted", 32'(halted), 32'd1);
    cyc(1, 1, 9, 1);
    chk("reset_valid", 32'(id_valid), 32'd0);
    chk("reset_idpc", 32'(id_pc), 32'd0);
    chk("reset_pc", 32'(imem_addr), 32'd0);

    // Random traffic with sprinkled jumps and halt idioms
    for (int i = 0; i < 64; i++) begin
      logic [16:0] w;
      w = 17'($urandom);
      case ($urandom_range(0, 7))
        0: w = {w[16], 4'b1011, w[11:6], 6'(i)};
        1: w[15:12] = 4'b1011;
        default: if (w[15:12] == 4'b1011) w[15:12] = 4'b0000;
      endcase
      mem[i] = w;
    end
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 9) == 0),
          6'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
